// File: rtl/otter_mmio_pkg.sv
// Shared address map, register decode and parameter sanity check for the
// OTTER memory-mapped IO hub.
package otter_mmio_pkg;

  localparam logic [31:0] ADDR_SW       = 32'h1100_0000;
  localparam logic [31:0] ADDR_LEDS     = 32'h1100_0020;
  localparam logic [31:0] ADDR_SSEG     = 32'h1100_0040;
  localparam logic [31:0] ADDR_BTN      = 32'h1100_0060;
  localparam logic [31:0] ADDR_IRQ_PEND = 32'h1100_0080;
  localparam logic [31:0] ADDR_IRQ_EN   = 32'h1100_00A0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SW,
    SEL_LEDS,
    SEL_SSEG,
    SEL_BTN,
    SEL_IRQ_PEND,
    SEL_IRQ_EN
  } reg_sel_e;

  // Full 32-bit compare: any address outside the map selects nothing.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    case (addr)
      ADDR_SW:       return SEL_SW;
      ADDR_LEDS:     return SEL_LEDS;
      ADDR_SSEG:     return SEL_SSEG;
      ADDR_BTN:      return SEL_BTN;
      ADDR_IRQ_PEND: return SEL_IRQ_PEND;
      ADDR_IRQ_EN:   return SEL_IRQ_EN;
      default:       return SEL_NONE;
    endcase
  endfunction

  function automatic bit params_ok(input int sw_w, input int led_w,
                                   input int n_btn, input int db_cycles);
    return (sw_w >= 1) && (sw_w <= 32) &&
           (led_w >= 1) && (led_w <= 32) &&
           (n_btn >= 1) && (n_btn <= 8) &&
           (db_cycles >= 2);
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One-bit button conditioner: two-flop synchroniser, stability counter,
// accepted level and a one-cycle pulse on each accepted 0->1 transition.
module mmio_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic accepted,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             acc_q, acc_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the
  // accepted level; the DB_CYCLES-th disagreeing clock flips the level.
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = sync2_q;
        cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_MAX;
      end
    end
    rise_d = acc_d & ~acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      acc_q   <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accepted = acc_q;
  assign rise     = rise_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// OTTER MMIO hub: switches, LEDs, seven-segment value, debounced buttons
// and a level interrupt with per-button pending/enable registers.
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter int SW_WIDTH  = 16,
  parameter int LED_WIDTH = 16,
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  input  logic [N_BTN-1:0]     BTNS,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic [15:0]          SSEG_DATA,
  output logic                 INTR
);

  localparam bit CFG_OK = params_ok(SW_WIDTH, LED_WIDTH, N_BTN, DB_CYCLES);

  if (!CFG_OK) begin : g_cfg_err
    $error("otter_mmio_hub: parameter out of range");
  end

  reg_sel_e             sel;
  logic [SW_WIDTH-1:0]  sw_sync1_q, sw_sync2_q;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [15:0]          sseg_q, sseg_d;
  logic [N_BTN-1:0]     irq_en_q, irq_en_d;
  logic [N_BTN-1:0]     pend_q, pend_d;
  logic [N_BTN-1:0]     pend_clr;
  logic                 intr_q, intr_d;
  logic [N_BTN-1:0]     btn_acc, btn_rise;
  logic [31:0]          rd_data;
  logic                 unused_wdata;

  assign unused_wdata = ^IOBUS_OUT;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    mmio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk      (CLK),
      .rst      (RST),
      .btn_raw  (BTNS[i]),
      .accepted (btn_acc[i]),
      .rise     (btn_rise[i])
    );
  end

  assign sel = decode_addr(IOBUS_ADDR);

  // A new rising edge is OR-ed in after the W1C mask, so set beats clear.
  always_comb begin
    leds_d   = leds_q;
    sseg_d   = sseg_q;
    irq_en_d = irq_en_q;
    pend_clr = '0;
    if (IOBUS_WR) begin
      case (sel)
        SEL_LEDS:     leds_d   = IOBUS_OUT[LED_WIDTH-1:0];
        SEL_SSEG:     sseg_d   = IOBUS_OUT[15:0];
        SEL_IRQ_EN:   irq_en_d = IOBUS_OUT[N_BTN-1:0];
        SEL_IRQ_PEND: pend_clr = IOBUS_OUT[N_BTN-1:0];
        default:      ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | btn_rise;
    intr_d = |(pend_q & irq_en_q);
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_SW:       rd_data = 32'(sw_sync2_q);
      SEL_LEDS:     rd_data = 32'(leds_q);
      SEL_SSEG:     rd_data = 32'(sseg_q);
      SEL_BTN:      rd_data = 32'(btn_acc);
      SEL_IRQ_PEND: rd_data = 32'(pend_q);
      SEL_IRQ_EN:   rd_data = 32'(irq_en_q);
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      leds_q     <= '0;
      sseg_q     <= '0;
      irq_en_q   <= '0;
      pend_q     <= '0;
      intr_q     <= 1'b0;
    end else begin
      sw_sync1_q <= SWITCHES;
      sw_sync2_q <= sw_sync1_q;
      leds_q     <= leds_d;
      sseg_q     <= sseg_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      intr_q     <= intr_d;
    end
  end

  assign IOBUS_IN  = rd_data;
  assign LEDS      = leds_q;
  assign SSEG_DATA = sseg_q;
  assign INTR      = intr_q;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed bench for otter_mmio_hub with a short debounce window (4 clocks).
module tb_otter_mmio_hub;

  localparam logic [31:0] A_SW   = 32'h1100_0000;
  localparam logic [31:0] A_LEDS = 32'h1100_0020;
  localparam logic [31:0] A_SSEG = 32'h1100_0040;
  localparam logic [31:0] A_BTN  = 32'h1100_0060;
  localparam logic [31:0] A_PEND = 32'h1100_0080;
  localparam logic [31:0] A_EN   = 32'h1100_00A0;
  localparam logic [31:0] A_BAD  = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES = '0;
  logic [3:0]  BTNS = '0;
  logic [15:0] LEDS;
  logic [15:0] SSEG_DATA;
  logic        INTR;

  int total = 0;
  int bad = 0;

  otter_mmio_hub #(
    .SW_WIDTH(16), .LED_WIDTH(16), .N_BTN(4), .DB_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES),
    .BTNS(BTNS), .LEDS(LEDS), .SSEG_DATA(SSEG_DATA), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  // Called at a falling edge; returns at the falling edge after the write.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = IOBUS_IN;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (LEDS !== 16'h0) begin bad++; $display("FAIL rst_leds got %h want 0000", LEDS); end
    total++; if (SSEG_DATA !== 16'h0) begin bad++; $display("FAIL rst_sseg got %h want 0000", SSEG_DATA); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL rst_intr got %b want 0", INTR); end
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_pend got %h want 0", rd); end
    bus_read(A_EN, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_en got %h want 0", rd); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_leds_sseg();
    logic [31:0] rd;
    bus_write(A_LEDS, 32'h0000_A5A5);
    total++; if (LEDS !== 16'hA5A5) begin bad++; $display("FAIL leds_out got %h want a5a5", LEDS); end
    bus_read(A_LEDS, rd);
    total++; if (rd !== 32'h0000_A5A5) begin bad++; $display("FAIL leds_rd got %h want 0000a5a5", rd); end
    bus_read(A_BAD, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd got %h want 0", rd); end
    @(negedge CLK);
    bus_write(A_SSEG, 32'hFFFF_1234);
    total++; if (SSEG_DATA !== 16'h1234) begin bad++; $display("FAIL sseg_out got %h want 1234", SSEG_DATA); end
    bus_read(A_SSEG, rd);
    total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL sseg_rd got %h want 00001234", rd); end
    @(negedge CLK);
    bus_write(A_BAD, 32'h0000_0F0F);
    total++; if (LEDS !== 16'hA5A5) begin bad++; $display("FAIL unmapped_wr got %h want a5a5", LEDS); end
  endtask

  task automatic test_switches();
    logic [31:0] rd;
    SWITCHES = 16'h1234;
    @(negedge CLK);
    bus_read(A_SW, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_edge1 got %h want 0", rd); end
    @(negedge CLK);
    bus_read(A_SW, rd);
    total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL sw_edge2 got %h want 00001234", rd); end
    @(negedge CLK);
    bus_write(A_SW, 32'h0000_FFFF);
    bus_read(A_SW, rd);
    total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL sw_ro got %h want 00001234", rd); end
    total++; if (LEDS !== 16'hA5A5) begin bad++; $display("FAIL sw_wr_leds got %h want a5a5", LEDS); end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    int early = 0;
    for (int i = 0; i < 10; i++) begin
      BTNS[0] = ~BTNS[0];
      repeat (2) begin
        @(negedge CLK);
        bus_read(A_BTN, rd);
        if (rd !== 32'h0) early++;
      end
    end
    total++; if (early != 0) begin bad++; $display("FAIL bounce_reject got %0d accepted cycles want 0", early); end
    BTNS[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      bus_read(A_BTN, rd);
      total++;
      if (rd !== ((k >= 6) ? 32'h1 : 32'h0)) begin
        bad++; $display("FAIL btn0_edge%0d got %h want %h", k, rd, (k >= 6) ? 32'h1 : 32'h0);
      end
      bus_read(A_PEND, rd);
      total++;
      if (rd !== ((k >= 7) ? 32'h1 : 32'h0)) begin
        bad++; $display("FAIL pend0_edge%0d got %h want %h", k, rd, (k >= 7) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_intr();
    logic [31:0] rd;
    @(negedge CLK);
    bus_write(A_EN, 32'h1);
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL intr_lat0 got %b want 0", INTR); end
    bus_read(A_EN, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL en_rd got %h want 1", rd); end
    @(negedge CLK);
    total++; if (INTR !== 1'b1) begin bad++; $display("FAIL intr_set got %b want 1", INTR); end
    bus_write(A_PEND, 32'h0);
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL w0_keeps got %h want 1", rd); end
    @(negedge CLK);
    bus_write(A_PEND, 32'h1);
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c got %h want 0", rd); end
    total++; if (INTR !== 1'b1) begin bad++; $display("FAIL intr_hold got %b want 1", INTR); end
    @(negedge CLK);
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL intr_clr got %b want 0", INTR); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    BTNS[1] = 1'b1;
    repeat (6) @(negedge CLK);
    IOBUS_ADDR = A_PEND;
    IOBUS_OUT  = 32'h2;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL race_set_wins got %h want 2", rd); end
    bus_read(A_BTN, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL race_btn got %h want 3", rd); end
    @(negedge CLK);
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL intr_masked got %b want 0", INTR); end
    bus_write(A_PEND, 32'h2);
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL race_clear got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    BTNS = 4'h0;
    repeat (8) @(negedge CLK);
    BTNS = 4'hF;
    repeat (7) @(negedge CLK);
    bus_read(A_PEND, rd);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL all_pend got %h want f", rd); end
    bus_write(A_LEDS, 32'hFFFF);
    total++; if (INTR !== 1'b1) begin bad++; $display("FAIL pre_rst_intr got %b want 1", INTR); end
    BTNS = 4'h0;
    repeat (8) @(negedge CLK);
    BTNS[2] = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    IOBUS_ADDR = A_LEDS;
    IOBUS_OUT  = 32'h1234;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    IOBUS_WR = 1'b0;
    total++; if (LEDS !== 16'h0) begin bad++; $display("FAIL mid_rst_leds got %h want 0000", LEDS); end
    total++; if (SSEG_DATA !== 16'h0) begin bad++; $display("FAIL mid_rst_sseg got %h want 0000", SSEG_DATA); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL mid_rst_intr got %b want 0", INTR); end
    bus_read(A_EN, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_rst_en got %h want 0", rd); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      bus_read(A_BTN, rd);
      total++;
      if (rd !== ((k >= 6) ? 32'h4 : 32'h0)) begin
        bad++; $display("FAIL post_rst_btn%0d got %h want %h", k, rd, (k >= 6) ? 32'h4 : 32'h0);
      end
      bus_read(A_PEND, rd);
      total++;
      if (rd !== ((k >= 7) ? 32'h4 : 32'h0)) begin
        bad++; $display("FAIL post_rst_pend%0d got %h want %h", k, rd, (k >= 7) ? 32'h4 : 32'h0);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_leds_sseg();
    test_switches();
    test_debounce();
    test_intr();
    test_w1c_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
